frame_controller: RTL and testbench

FRAME_CONTROLLER -- requirements
Module: frame_controller

---
 rtl/frame_controller_if.sv | 44 ++++
 rtl/frame_controller.sv | 170 +++++++++++++++++
 tb/tb_frame_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_controller_if.sv
// Rasterizer pixel handshake and framebuffer write port of the frame controller.
// slave is the controller's view; master is the rasterizer/framebuffer view.
interface frame_controller_if;
  logic        draw_valid_in;
  logic        draw_ready_out;
  logic [8:0]  draw_x_in;
  logic [7:0]  draw_y_in;
  logic [7:0]  draw_z_in;
  logic [11:0] draw_rgb_in;

  logic        valid_out;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [7:0]  z_out;
  logic [11:0] rgb_out;

  modport slave (
    input  draw_valid_in,
    input  draw_x_in,
    input  draw_y_in,
    input  draw_z_in,
    input  draw_rgb_in,
    output draw_ready_out,
    output valid_out,
    output x_out,
    output y_out,
    output z_out,
    output rgb_out
  );

  modport master (
    output draw_valid_in,
    output draw_x_in,
    output draw_y_in,
    output draw_z_in,
    output draw_rgb_in,
    input  draw_ready_out,
    input  valid_out,
    input  x_out,
    input  y_out,
    input  z_out,
    input  rgb_out
  );
endinterface

// File: rtl/frame_controller.sv
// Frame controller: clears a 320x240 buffer, forwards rasterizer pixels, swaps on frame tick.
// Statistics counters are built only when FRAME_STATS_EN is defined.
module frame_controller #(
  parameter logic [11:0] CLEAR_RGB = 12'h000,
  parameter logic [7:0]  CLEAR_Z   = 8'hFF
) (
  input  logic                     gpu_clk_in,
  input  logic                     rst_in,
  input  logic                     frame_tick_in,
  frame_controller_if.slave        fb_if,
  output logic                     switch_out,
  output logic                     clear_busy_out,
  output logic [15:0]              frame_count_out,
  output logic [7:0]               overrun_count_out
);

  localparam logic [8:0] XLast = 9'd319;
  localparam logic [7:0] YLast = 8'd239;

  typedef enum logic [1:0] {StClear, StDraw, StSwap} state_e;

  state_e      state_q, state_d;
  logic [8:0]  sweep_x_q, sweep_x_d;
  logic [7:0]  sweep_y_q, sweep_y_d;
  logic        valid_q, valid_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  z_q, z_d;
  logic [11:0] rgb_q, rgb_d;
  logic        switch_q, switch_d;
  logic        clear_busy_q, clear_busy_d;
  logic        draw_ready;

  // A tick takes priority over a pixel so no write lands in the switch cycle.
  assign draw_ready = (state_q == StDraw) && !frame_tick_in;

  always_comb begin
    state_d   = state_q;
    sweep_x_d = sweep_x_q;
    sweep_y_d = sweep_y_q;
    valid_d   = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    rgb_d     = rgb_q;
    switch_d  = 1'b0;

    unique case (state_q)
      StClear: begin
        valid_d = 1'b1;
        x_d     = sweep_x_q;
        y_d     = sweep_y_q;
        z_d     = CLEAR_Z;
        rgb_d   = CLEAR_RGB;
        if (sweep_x_q == XLast) begin
          sweep_x_d = '0;
          if (sweep_y_q == YLast) begin
            sweep_y_d = '0;
            state_d   = StDraw;
          end else begin
            sweep_y_d = sweep_y_q + 8'd1;
          end
        end else begin
          sweep_x_d = sweep_x_q + 9'd1;
        end
      end
      StDraw: begin
        if (frame_tick_in) begin
          switch_d = 1'b1;
          state_d  = StSwap;
        end else if (fb_if.draw_valid_in) begin
          valid_d = 1'b1;
          x_d     = fb_if.draw_x_in;
          y_d     = fb_if.draw_y_in;
          z_d     = fb_if.draw_z_in;
          rgb_d   = fb_if.draw_rgb_in;
        end
      end
      StSwap: begin
        // Switch cycle is on the port now; issue the sweep's first write (0,0) here.
        valid_d   = 1'b1;
        x_d       = '0;
        y_d       = '0;
        z_d       = CLEAR_Z;
        rgb_d     = CLEAR_RGB;
        sweep_x_d = 9'd1;
        sweep_y_d = '0;
        state_d   = StClear;
      end
      default: begin
        sweep_x_d = '0;
        sweep_y_d = '0;
        state_d   = StClear;
      end
    endcase

    clear_busy_d = (state_d == StClear);
  end

  always_ff @(posedge gpu_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StClear;
      sweep_x_q    <= '0;
      sweep_y_q    <= '0;
      valid_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      rgb_q        <= '0;
      switch_q     <= 1'b0;
      clear_busy_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sweep_x_q    <= sweep_x_d;
      sweep_y_q    <= sweep_y_d;
      valid_q      <= valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      rgb_q        <= rgb_d;
      switch_q     <= switch_d;
      clear_busy_q <= clear_busy_d;
    end
  end

`ifdef FRAME_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  overrun_cnt_q, overrun_cnt_d;
  logic        tick_drop;

  assign tick_drop = frame_tick_in && (state_q != StDraw);

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    overrun_cnt_d = overrun_cnt_q;
    if (switch_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (tick_drop && (overrun_cnt_q != 8'hFF)) begin
      overrun_cnt_d = overrun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge gpu_clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign frame_count_out   = frame_cnt_q;
  assign overrun_count_out = overrun_cnt_q;
`else
  assign frame_count_out   = '0;
  assign overrun_count_out = '0;
`endif

  assign fb_if.draw_ready_out = draw_ready;
  assign fb_if.valid_out      = valid_q;
  assign fb_if.x_out          = x_q;
  assign fb_if.y_out          = y_q;
  assign fb_if.z_out          = z_q;
  assign fb_if.rgb_out        = rgb_q;
  assign switch_out           = switch_q;
  assign clear_busy_out       = clear_busy_q;

endmodule

// File: tb/tb_frame_controller.sv
// Self-checking bench for frame_controller: scoreboarded write port, vector table for DRAW,
// hand sequences for swap timing, dropped ticks and mid-sweep reset.
module tb_frame_controller;

  localparam logic [11:0] ClrRgb = 12'h3C7;
  localparam logic [7:0]  ClrZ   = 8'hFF;
`ifdef FRAME_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [7:0]  z;
    logic [11:0] rgb;
  } wr_t;

  typedef struct {
    bit          v;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [7:0]  z;
    logic [11:0] rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        switch_out;
  logic        clear_busy;
  logic [15:0] frame_cnt;
  logic [7:0]  ovr_cnt;

  frame_controller_if fb_if ();

  frame_controller #(
    .CLEAR_RGB (ClrRgb),
    .CLEAR_Z   (ClrZ)
  ) dut (
    .gpu_clk_in        (clk),
    .rst_in            (rst),
    .frame_tick_in     (tick),
    .fb_if             (fb_if),
    .switch_out        (switch_out),
    .clear_busy_out    (clear_busy),
    .frame_count_out   (frame_cnt),
    .overrun_count_out (ovr_cnt)
  );

  always #5 clk = ~clk;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  writes_seen = 0;
  int  switch_seen = 0;
  int  overlap_seen = 0;
  bit  mon_en = 1'b0;
  wr_t mon_got;
  wr_t mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic push_clear(input int first, input int last);
    wr_t w;
    for (int i = first; i <= last; i++) begin
      w.x   = 9'(i % 320);
      w.y   = 8'(i / 320);
      w.z   = ClrZ;
      w.rgb = ClrRgb;
      sb.push_back(w);
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      nxt();
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic drive(input bit v, input logic [8:0] x, input logic [7:0] y,
                       input logic [7:0] z, input logic [11:0] rgb);
    fb_if.draw_valid_in = v;
    fb_if.draw_x_in     = x;
    fb_if.draw_y_in     = y;
    fb_if.draw_z_in     = z;
    fb_if.draw_rgb_in   = rgb;
  endtask

  // Scoreboard: every write on the port must match the head of the expectation queue.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (switch_out) switch_seen++;
      if (switch_out && fb_if.valid_out) overlap_seen++;
      if (fb_if.valid_out) begin
        writes_seen++;
        mon_got = '{fb_if.x_out, fb_if.y_out, fb_if.z_out, fb_if.rgb_out};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got x=%0d y=%0d z=%0h rgb=%0h, expected no write",
                   mon_got.x, mon_got.y, mon_got.z, mon_got.rgb);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL write_data: got x=%0d y=%0d z=%0h rgb=%0h, expected x=%0d y=%0d z=%0h rgb=%0h",
                     mon_got.x, mon_got.y, mon_got.z, mon_got.rgb,
                     mon_exp.x, mon_exp.y, mon_exp.z, mon_exp.rgb);
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    wr_t  w;

    vecs[0] = '{1'b1, 9'd10,  8'd20,  8'd5,   12'hF00};
    vecs[1] = '{1'b0, 9'd77,  8'd66,  8'd55,  12'h444};
    vecs[2] = '{1'b1, 9'd0,   8'd0,   8'd0,   12'h000};
    vecs[3] = '{1'b1, 9'd511, 8'd255, 8'd255, 12'hFFF};
    vecs[4] = '{1'b1, 9'd319, 8'd239, 8'd128, 12'h0F0};
    vecs[5] = '{1'b0, 9'd1,   8'd2,   8'd3,   12'h123};
    vecs[6] = '{1'b1, 9'd256, 8'd128, 8'd1,   12'hA5A};
    vecs[7] = '{1'b1, 9'd3,   8'd4,   8'd200, 12'h00F};

    rst  = 1'b1;
    tick = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    #12;
    check("reset_write_port", {fb_if.valid_out, fb_if.x_out, fb_if.y_out, fb_if.z_out,
                               fb_if.rgb_out}, 64'd0);
    check("reset_switch_stats", {switch_out, frame_cnt, ovr_cnt}, 64'd0);
    check("reset_busy_ready", {clear_busy, fb_if.draw_ready_out}, 64'b10);

    // Full clear sweep with one dropped tick at sweep index 1000.
    push_clear(0, 76799);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    writes_seen = 0;
    nxt();
    check("first_clear_write", {fb_if.valid_out, fb_if.x_out, fb_if.y_out}, {1'b1, 17'd0});
    begin
      int n = 0;
      while (writes_seen < 1000 && n < 2000) begin
        nxt();
        n++;
      end
    end
    check("reach_index_1000", 64'(writes_seen), 64'd1000);
    tick = 1'b1;
    #1;
    check("ready_low_in_clear", 64'(fb_if.draw_ready_out), 64'd0);
    nxt();
    tick = 1'b0;
    wait_drain("sweep_drain", 80000);
    check("sweep_last_xy", {fb_if.x_out, fb_if.y_out}, {9'd319, 8'd239});
    check("sweep_write_count", 64'(writes_seen), 64'd76800);
    check("no_switch_on_drop", 64'(switch_seen), 64'd0);
    check("overrun_after_drop", 64'(ovr_cnt), StatsEn ? 64'd1 : 64'd0);
    check("draw_state_flags", {clear_busy, fb_if.draw_ready_out}, 64'b01);
    nxt();
    check("idle_after_sweep", {fb_if.valid_out, fb_if.draw_ready_out}, 64'b01);

    // Table of DRAW-state pixels: each accepted one must be written unmodified.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].rgb);
      if (vecs[i].v) sb.push_back('{vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].rgb});
      #1;
      check($sformatf("vec%0d_ready", i), 64'(fb_if.draw_ready_out), 64'd1);
      nxt();
    end
    drive(1'b0, '0, '0, '0, '0);
    nxt();
    check("table_drained", 64'(sb.size()), 64'd0);

    // Single pixel: present in the next cycle only.
    drive(1'b1, 9'd10, 8'd20, 8'd5, 12'hF00);
    sb.push_back('{9'd10, 8'd20, 8'd5, 12'hF00});
    nxt();
    drive(1'b0, '0, '0, '0, '0);
    check("pixel_latency", {fb_if.valid_out, fb_if.x_out, fb_if.y_out, fb_if.z_out,
                            fb_if.rgb_out}, {1'b1, 9'd10, 8'd20, 8'd5, 12'hF00});
    nxt();
    check("pixel_one_cycle", 64'(fb_if.valid_out), 64'd0);

    // Pixel at T-1, tick at T: write in T, switch in T+1, clear (0,0) in T+2.
    drive(1'b1, 9'd7, 8'd9, 8'd3, 12'h0F0);
    sb.push_back('{9'd7, 8'd9, 8'd3, 12'h0F0});
    nxt();
    check("pre_tick_write", {fb_if.valid_out, fb_if.x_out, fb_if.y_out}, {1'b1, 9'd7, 8'd9});
    drive(1'b1, 9'd200, 8'd100, 8'd9, 12'hBAD);
    tick = 1'b1;
    #1;
    check("ready_low_on_tick", 64'(fb_if.draw_ready_out), 64'd0);
    nxt();
    tick = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    check("switch_cycle", {switch_out, fb_if.valid_out}, 64'b10);
    check("frame_count_1", 64'(frame_cnt), StatsEn ? 64'd1 : 64'd0);
    push_clear(0, 16100);
    nxt();
    check("clear_restart", {fb_if.valid_out, fb_if.x_out, fb_if.y_out, switch_out, clear_busy},
          {1'b1, 9'd0, 8'd0, 1'b0, 1'b1});

    // 300 ticks dropped during the clear sweep.
    for (int i = 0; i < 300; i++) begin
      tick = 1'b1;
      #1;
      check("ready_low_storm", 64'(fb_if.draw_ready_out), 64'd0);
      nxt();
      tick = 1'b0;
      nxt();
    end
    check("overrun_saturate", 64'(ovr_cnt), StatsEn ? 64'hFF : 64'd0);

    // Asynchronous reset while (100,50) is on the port.
    wait_drain("reach_100_50", 17000);
    check("at_100_50", {fb_if.valid_out, fb_if.x_out, fb_if.y_out}, {1'b1, 9'd100, 8'd50});
    rst = 1'b1;
    #1;
    check("async_reset_port", {fb_if.valid_out, fb_if.x_out, fb_if.y_out, fb_if.z_out,
                               fb_if.rgb_out, switch_out}, 64'd0);
    check("async_reset_stats", {frame_cnt, ovr_cnt}, 64'd0);
    nxt();
    nxt();
    check("held_reset_port", {fb_if.valid_out, switch_out, clear_busy}, 64'b001);
    rst = 1'b0;
    push_clear(0, 3);
    nxt();
    check("restart_00", {fb_if.valid_out, fb_if.x_out, fb_if.y_out}, {1'b1, 17'd0});
    nxt();
    nxt();
    nxt();
    mon_en = 1'b0;
    check("restart_drained", 64'(sb.size()), 64'd0);
    check("total_switches", 64'(switch_seen), 64'd1);
    check("no_write_switch_overlap", 64'(overlap_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
